definition_of_idle: RTL and testbench



---
 rtl/definition_of_idle_pkg.sv | 32 +++
 rtl/definition_of_idle_cc_sync_deglitch.sv | 69 ++++++
 rtl/definition_of_idle.sv | 151 +++++++++++++++
 tb/tb_definition_of_idle.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/definition_of_idle_pkg.sv
// -----------------------------------------------------------------------------
// definition_of_idle_pkg
//   Shared constants and types for the CC-line idle detector. The TX control
//   timers use the same window/threshold defaults, so they live here rather
//   than in the detector itself.
//
//   Contents:
//     idle_state_t         : ST_OFF / ST_MEASURE state encoding
//     TIMER_W              : width of the window timer
//     DEF_WINDOW_CYCLES    : default window length in clk cycles (~16 us @ 50 MHz)
//     DEF_TRANS_THRESH     : transition count at or above which the line is busy
//     DEF_FILTER_CYCLES    : consecutive stable samples needed to accept a level
//     sat_cnt_w()          : width of a counter that saturates at a given value
// -----------------------------------------------------------------------------
package definition_of_idle_pkg;

    typedef enum logic {
        ST_OFF     = 1'b0,
        ST_MEASURE = 1'b1
    } idle_state_t;

    localparam int                 TIMER_W           = 11;
    localparam logic [TIMER_W-1:0] DEF_WINDOW_CYCLES = 11'd800;
    localparam int                 DEF_TRANS_THRESH  = 3;
    localparam int                 DEF_FILTER_CYCLES = 3;

    // Bits needed to hold values 0..sat_val inclusive.
    function automatic int sat_cnt_w(input int sat_val);
        return (sat_val < 1) ? 1 : $clog2(sat_val + 1);
    endfunction

endpackage

// File: rtl/definition_of_idle_cc_sync_deglitch.sv
// -----------------------------------------------------------------------------
// cc_sync_deglitch
//   Front end for the raw CC comparator output: a 2-flop synchroniser followed
//   by a run-length deglitch filter. A new level is accepted only after
//   FILTER_CYCLES consecutive synchronised samples disagree with the current
//   filtered level; any shorter excursion is thrown away. cc_edge pulses for
//   one cycle, in the same cycle the filtered level changes.
//
//   Latency: a stable change on cc_rx_in shows up on cc_edge 2 + FILTER_CYCLES
//   cycles later (2 synchroniser flops, then FILTER_CYCLES filter samples).
//
//   Ports:
//     clk       in   system clock
//     rst_n     in   asynchronous active-low reset
//     cc_rx_in  in   raw asynchronous CC comparator output
//     cc_edge   out  one-cycle pulse when the filtered level toggles
// -----------------------------------------------------------------------------
module cc_sync_deglitch
    import definition_of_idle_pkg::*;
#(
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cc_rx_in,
    output logic cc_edge
);

    localparam int FCNT_W = sat_cnt_w(FILTER_CYCLES);

    logic              sync_q1;
    logic              sync_q2;
    logic [FCNT_W-1:0] fcnt;
    logic              level_q;
    logic              edge_q;
    logic              differ;
    logic              accept;

    // fcnt holds how many disagreeing samples have already been seen, so the
    // current sample is the last one needed when fcnt == FILTER_CYCLES-1.
    assign differ = (sync_q2 != level_q);
    assign accept = differ && (fcnt == FCNT_W'(FILTER_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            fcnt    <= '0;
            level_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync_q1 <= cc_rx_in;
            sync_q2 <= sync_q1;
            edge_q  <= accept;
            if (!differ) begin
                // Any agreeing sample breaks the run.
                fcnt <= '0;
            end else if (accept) begin
                level_q <= sync_q2;
                fcnt    <= '0;
            end else begin
                fcnt <= fcnt + FCNT_W'(1);
            end
        end
    end

    assign cc_edge = edge_q;

endmodule

// File: rtl/definition_of_idle.sv
// -----------------------------------------------------------------------------
// definition_of_idle
//   CC-line idle detector feeding the TX control check-CC / wait-CC-idle steps.
//   While definition_of_idle_en is high, filtered CC transitions are counted
//   over back-to-back windows of WINDOW_CYCLES cycles. At the end of every
//   completed window a one-cycle done pulse is issued together with the
//   verdict: idle when fewer than TRANS_THRESH transitions were seen.
//
//   Window timing: the first en-high cycle (still in ST_OFF) is window cycle 0
//   and counts edges. The cycle after window cycle WINDOW_CYCLES-1 carries the
//   done pulse and is itself cycle 0 of the next window, so the first done
//   lands exactly WINDOW_CYCLES cycles after en rises and every WINDOW_CYCLES
//   cycles thereafter.
//
//   Dropping en abandons the current window with no done; result keeps the
//   last verdict so the consumer can sample it at any time.
//
//   Ports:
//     clk                          in   system clock
//     rst_n                        in   asynchronous active-low reset
//     definition_of_idle_en        in   level request, measurement runs while high
//     cc_rx_in                     in   raw asynchronous CC comparator output
//     definition_of_idle_done      out  one-cycle pulse at the end of each window
//     definition_of_idle_result    out  1 = idle, 0 = busy; held between dones
//     definition_of_idle_trans_cnt out  debug, saturating count of current window
// -----------------------------------------------------------------------------
module definition_of_idle
    import definition_of_idle_pkg::*;
#(
    parameter logic [TIMER_W-1:0] WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int                 TRANS_THRESH  = DEF_TRANS_THRESH,
    parameter int                 FILTER_CYCLES = DEF_FILTER_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       definition_of_idle_en,
    input  logic       cc_rx_in,
    output logic       definition_of_idle_done,
    output logic       definition_of_idle_result,
    output logic [1:0] definition_of_idle_trans_cnt
);

    localparam int                 CNT_W      = sat_cnt_w(TRANS_THRESH);
    localparam logic [CNT_W-1:0]   CNT_SAT    = CNT_W'(TRANS_THRESH);
    localparam logic [TIMER_W-1:0] TIMER_LAST = WINDOW_CYCLES - TIMER_W'(1);

    idle_state_t        state;
    idle_state_t        state_d;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   cnt_final;
    logic               done_q;
    logic               done_d;
    logic               result_q;
    logic               result_d;
    logic               cc_edge;
    logic               window_last;

    // -------------------------------------------------------------------------
    // Input path: runs regardless of en so the baseline level has already
    // settled by the time a measurement starts.
    // -------------------------------------------------------------------------
    cc_sync_deglitch #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_cc_sync_deglitch (
        .clk      (clk),
        .rst_n    (rst_n),
        .cc_rx_in (cc_rx_in),
        .cc_edge  (cc_edge)
    );

    // Count including this cycle's edge; this is what the verdict uses, so an
    // edge in the final window cycle still belongs to the ending window.
    assign cnt_final   = (cc_edge && (cnt != CNT_SAT)) ? cnt + CNT_W'(1) : cnt;
    assign window_last = (state == ST_MEASURE) && (timer == TIMER_LAST);

    // -------------------------------------------------------------------------
    // State register (plus the registered datapath/outputs it controls)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_OFF;
            timer    <= '0;
            cnt      <= '0;
            done_q   <= 1'b0;
            result_q <= 1'b0;
        end else begin
            state    <= state_d;
            timer    <= timer_d;
            cnt      <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state;
        unique case (state)
            ST_OFF:     if (definition_of_idle_en)  state_d = ST_MEASURE;
            ST_MEASURE: if (!definition_of_idle_en) state_d = ST_OFF;
            default:    state_d = ST_OFF;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath logic
    //   Default is the "off" behaviour: timer and count cleared, no done,
    //   verdict held. In ST_OFF timer and cnt are already zero, so the en-high
    //   cycle there is handled exactly like an ordinary window cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        timer_d  = '0;
        cnt_d    = '0;
        done_d   = 1'b0;
        result_d = result_q;
        unique case (state)
            ST_OFF: begin
                if (definition_of_idle_en) begin
                    timer_d = TIMER_W'(1);
                    cnt_d   = cnt_final;
                end
            end
            ST_MEASURE: begin
                if (definition_of_idle_en) begin
                    if (window_last) begin
                        // Wrap: timer/cnt restart, done cycle is the next
                        // window's cycle 0.
                        done_d   = 1'b1;
                        result_d = (cnt_final < CNT_SAT);
                    end else begin
                        timer_d = timer + TIMER_W'(1);
                        cnt_d   = cnt_final;
                    end
                end
            end
            default: begin
                timer_d = '0;
            end
        endcase
    end

    assign definition_of_idle_done      = done_q;
    assign definition_of_idle_result    = result_q;
    assign definition_of_idle_trans_cnt = 2'(cnt);

endmodule

// File: tb/tb_definition_of_idle.sv
module tb_definition_of_idle;

    localparam int W  = 800;
    localparam int TH = 3;
    localparam int E  = 10;   // cycle in which en first rises

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       cc = 1'b0;
    logic       done;
    logic       result;
    logic [1:0] tcnt;

    definition_of_idle dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .definition_of_idle_en        (en),
        .cc_rx_in                     (cc),
        .definition_of_idle_done      (done),
        .definition_of_idle_result    (result),
        .definition_of_idle_trans_cnt (tcnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. The line level is accepted once the last three
    // samples seen after the 2-flop delay all disagree with it. Windows are
    // tracked as a position inside the current en-high run, modulo W, with
    // an unbounded edge tally per window.
    // ------------------------------------------------------------------
    bit hist[6];
    bit mlev = 1'b0;
    bit active = 1'b0;
    int ppos = 0;
    int wcount = 0;
    bit e_done = 1'b0;
    bit e_res = 1'b0;
    int e_cnt = 0;
    int n_done = 0;

    always @(negedge clk) begin
        bit edge_now;
        if (!rst_n) begin
            chk("rst_done",   int'(done),   0);
            chk("rst_result", int'(result), 0);
            chk("rst_cnt",    int'(tcnt),   0);
            for (int k = 0; k < 6; k++) hist[k] = 1'b0;
            mlev = 1'b0; active = 1'b0; ppos = 0; wcount = 0;
            e_done = 1'b0; e_res = 1'b0; e_cnt = 0;
        end else begin
            chk("done",      int'(done),   int'(e_done));
            chk("result",    int'(result), int'(e_res));
            chk("trans_cnt", int'(tcnt),   e_cnt);
            if (done) n_done++;
            for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = cc;
            edge_now = (hist[3] != mlev) && (hist[4] != mlev) && (hist[5] != mlev);
            if (edge_now) mlev = ~mlev;
            if (en) begin
                if (active) begin
                    ppos = (ppos + 1) % W;
                    if (ppos == 0) wcount = 0;
                end else begin
                    ppos = 0;
                    wcount = 0;
                end
                active = 1'b1;
                if (edge_now) wcount++;
                if (ppos == W - 1) begin
                    e_done = 1'b1;
                    e_res  = (wcount < TH);
                    e_cnt  = 0;
                end else begin
                    e_done = 1'b0;
                    e_cnt  = (wcount < TH) ? wcount : TH;
                end
            end else begin
                active = 1'b0;
                e_done = 1'b0;
                e_cnt  = 0;
            end
        end
    end

    // Advance to 1 ns after the posedge that starts cycle c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Toggle cc so that the filtered edge lands 5 cycles later.
    task automatic tog_at(input int c);
        goto(c);
        cc = ~cc;
    endtask

    task automatic glitch(input int c, input int len);
        goto(c);
        cc = ~cc;
        goto(c + len);
        cc = ~cc;
    endtask

    task automatic chk_done(input string name, input int c, input int res);
        goto(c - 1);
        chk({name, "_pre"}, int'(done), 0);
        goto(c);
        chk({name, "_done"}, int'(done), 1);
        chk({name, "_res"}, int'(result), res);
    endtask

    initial begin
        int w, r, q, nd0;
        goto(3);
        rst_n = 1'b1;
        goto(E);
        en = 1'b1;

        // W1 quiet -> idle, done exactly 800 cycles after en rises
        chk_done("w1", E + 800, 1);

        // W2: three clean edges at window cycles 100/200/300 -> busy
        w = E + 800;
        tog_at(w + 95); tog_at(w + 195); tog_at(w + 295);
        goto(w + 799);
        chk("w2_cnt_sat", int'(tcnt), 3);
        chk_done("w2", w + 800, 0);

        // W3 quiet -> idle again
        chk_done("w3", E + 2400, 1);

        // W4: two edges plus 1- and 2-cycle glitches -> still 2, idle
        w = E + 2400;
        tog_at(w + 95); tog_at(w + 195);
        glitch(w + 400, 1);
        glitch(w + 500, 2);
        goto(w + 799);
        chk("w4_cnt", int'(tcnt), 2);
        chk_done("w4", w + 800, 1);

        // W5: third edge lands in window cycle 799 -> counted, busy
        w = E + 3200;
        tog_at(w + 95); tog_at(w + 195); tog_at(w + 794);
        goto(w + 799);
        chk("w5_cnt", int'(tcnt), 2);
        chk_done("w5", w + 800, 0);

        // W6: two edges, third lands in cycle 800 -> belongs to W7
        w = E + 4000;
        tog_at(w + 95); tog_at(w + 195); tog_at(w + 795);
        chk_done("w6", w + 800, 1);
        goto(w + 801);
        chk("w7_cnt_first", int'(tcnt), 1);
        w = E + 4800;
        tog_at(w + 95); tog_at(w + 195);
        chk_done("w7", w + 800, 0);

        // W8: en dropped at window cycle 400, re-raised 50 cycles later
        w = E + 5600;
        goto(w + 400);
        en = 1'b0;
        nd0 = n_done;
        goto(w + 450);
        chk("held_result", int'(result), 0);
        en = 1'b1;
        r = w + 450;
        goto(w + 800);
        chk("no_old_boundary_done", int'(done), 0);
        goto(r + 799);
        chk("no_done_while_off", n_done, nd0);
        chk_done("rerun", r + 800, 1);

        // Reset mid-window with two edges counted
        w = r + 800;
        tog_at(w + 95); tog_at(w + 195);
        goto(w + 400);
        chk("pre_rst_cnt", int'(tcnt), 2);
        chk("pre_rst_res", int'(result), 1);
        rst_n = 1'b0;
        #1;
        chk("async_done",   int'(done),   0);
        chk("async_result", int'(result), 0);
        chk("async_cnt",    int'(tcnt),   0);
        goto(w + 403);
        rst_n = 1'b1;
        q = w + 403;
        // cc is high here, so one filtered edge follows release: still idle
        chk_done("post_rst", q + 800, 1);
        goto(q + 805);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
